// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - memory-mapped 4-digit hex display scanner feeding a 7-segment decoder
module seg7_scan_driver #(
   parameter logic [7:0] BASE_ADDR   = 8'hD0,
   parameter int         REFRESH_DIV = 100000,
   parameter int         CNT_W       = 17
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] BUS_ADDR,
   input  logic [7:0] BUS_DATA,
   input  logic       BUS_WE,
   output logic [1:0] SEG_SELECT,
   output logic [3:0] BIN,
   output logic       DOT
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [15:0]      value;
   logic [7:0]       stage;
   logic [3:0]       dotmask;
   logic [3:0]       enmask;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic [1:0]       idx;
   logic [1:0]       idx_next;
   logic [3:0]       eff_mask;
   logic [1:0]       cand1;
   logic [1:0]       cand2;
   logic [1:0]       cand3;

   logic wr_stage;
   logic wr_value;
   logic wr_dot;
   logic wr_en;

   assign wr_stage = BUS_WE && (BUS_ADDR == BASE_ADDR);
   assign wr_value = BUS_WE && (BUS_ADDR == BASE_ADDR + 8'd1);
   assign wr_dot   = BUS_WE && (BUS_ADDR == BASE_ADDR + 8'd2);
   assign wr_en    = BUS_WE && (BUS_ADDR == BASE_ADDR + 8'd3);

   // Register file: low byte is staged so the 16-bit value commits atomically on the high-byte write
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         value   <= 16'h0000;
         stage   <= 8'h00;
         dotmask <= 4'h0;
         enmask  <= 4'hF;
      end else begin
         if (wr_stage) stage   <= BUS_DATA;
         if (wr_value) value   <= {BUS_DATA, stage};
         if (wr_dot)   dotmask <= BUS_DATA[3:0];
         if (wr_en)    enmask  <= BUS_DATA[3:0];
      end
   end

   assign tick = (cnt == CNT_LAST);

   // Prescaler: one tick per digit slot, wrapping after REFRESH_DIV cycles
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign cand1 = idx + 2'd1;
   assign cand2 = idx + 2'd2;
   assign cand3 = idx + 2'd3;

   // Next digit: first enabled digit in cyclic order after the current one; an all-zero mask means all on
   always_comb begin
      eff_mask = (enmask == 4'h0) ? 4'hF : enmask;
      idx_next = idx;
      if (eff_mask[cand1]) begin
         idx_next = cand1;
      end else if (eff_mask[cand2]) begin
         idx_next = cand2;
      end else if (eff_mask[cand3]) begin
         idx_next = cand3;
      end
   end

   // Scan index moves only on tick, so a disabled current digit stays until its slot ends
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idx <= 2'd0;
      end else if (tick) begin
         idx <= idx_next;
      end
   end

   // Registered decoder drive, refreshed every cycle from the current index and registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         SEG_SELECT <= 2'd0;
         BIN        <= 4'h0;
         DOT        <= 1'b0;
      end else begin
         SEG_SELECT <= idx;
         BIN        <= value[{idx, 2'b00} +: 4];
         DOT        <= dotmask[idx];
      end
   end

endmodule
